pwm_capture: RTL and testbench

//  Receive-side counterpart of the team's PWM generator. Samples an asynchronous PWM

---
 rtl/pwm_capture.sv | 155 +++++++++++++++
 tb/tb_pwm_capture.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM capture: synchronises an asynchronous PWM input and measures its high time and
// period in clock cycles, reporting one duty/period pair per completed period.
module pwm_capture #(
    parameter int CNT_W   = 12,
    parameter int TIMEOUT = (1 << CNT_W) - 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             pwm_i,
    output logic [CNT_W-1:0] duty_o,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    output logic             timeout_o,
    output logic             level_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    logic [1:0]       sync_reg;
    logic             s_d_reg;
    logic             rise_reg;
    logic             fall_reg;

    state_t           state_reg,   state_next;
    logic [CNT_W-1:0] per_cnt_reg, per_cnt_next;
    logic [CNT_W-1:0] hi_cnt_reg,  hi_cnt_next;
    logic [CNT_W-1:0] duty_reg,    duty_next;
    logic [CNT_W-1:0] period_reg,  period_next;
    logic             valid_reg,   valid_next;
    logic             timeout_reg, timeout_next;

    logic [CNT_W-1:0] per_inc;
    logic [CNT_W-1:0] hi_inc;
    logic             expired;

    // Two synchroniser flops, then a registered edge detector (3 cycles pin to edge).
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_reg <= 2'b00;
            s_d_reg  <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], pwm_i};
            s_d_reg  <= sync_reg[1];
            rise_reg <= sync_reg[1] & ~s_d_reg;
            fall_reg <= ~sync_reg[1] & s_d_reg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg   <= IDLE;
            per_cnt_reg <= '0;
            hi_cnt_reg  <= '0;
            duty_reg    <= '0;
            period_reg  <= '0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            per_cnt_reg <= per_cnt_next;
            hi_cnt_reg  <= hi_cnt_next;
            duty_reg    <= duty_next;
            period_reg  <= period_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
        end
    end

    // Counters stick at all-ones instead of wrapping.
    assign per_inc = (per_cnt_reg == CNT_MAX) ? per_cnt_reg : per_cnt_reg + CNT_ONE;
    assign hi_inc  = (hi_cnt_reg == CNT_MAX) ? hi_cnt_reg : hi_cnt_reg + CNT_ONE;
    assign expired = (per_cnt_reg == TIMEOUT_C);

    always_comb begin
        state_next   = state_reg;
        per_cnt_next = per_cnt_reg;
        hi_cnt_next  = hi_cnt_reg;
        duty_next    = duty_reg;
        period_next  = period_reg;
        valid_next   = 1'b0;
        timeout_next = timeout_reg;

        if (!enable_i) begin
            state_next   = IDLE;
            per_cnt_next = '0;
            hi_cnt_next  = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rise_reg) begin
                        state_next   = HIGH;
                        per_cnt_next = CNT_ONE;
                        hi_cnt_next  = CNT_ONE;
                    end
                end
                HIGH: begin
                    if (expired) begin
                        state_next   = IDLE;
                        timeout_next = 1'b1;
                        per_cnt_next = '0;
                        hi_cnt_next  = '0;
                    end else if (fall_reg) begin
                        state_next   = LOW;
                        per_cnt_next = per_inc;
                    end else begin
                        per_cnt_next = per_inc;
                        hi_cnt_next  = hi_inc;
                    end
                end
                LOW: begin
                    // A rise coinciding with the timeout count still completes the period.
                    if (rise_reg) begin
                        state_next   = HIGH;
                        period_next  = per_cnt_reg;
                        duty_next    = hi_cnt_reg;
                        valid_next   = 1'b1;
                        timeout_next = 1'b0;
                        per_cnt_next = CNT_ONE;
                        hi_cnt_next  = CNT_ONE;
                    end else if (expired) begin
                        state_next   = IDLE;
                        timeout_next = 1'b1;
                        per_cnt_next = '0;
                        hi_cnt_next  = '0;
                    end else begin
                        per_cnt_next = per_inc;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    per_cnt_next = '0;
                    hi_cnt_next  = '0;
                end
            endcase
        end
    end

    assign duty_o    = duty_reg;
    assign period_o  = period_reg;
    assign valid_o   = valid_reg;
    assign timeout_o = timeout_reg;
    assign level_o   = sync_reg[1];

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table of PWM waveforms with expected results, plus hand-written
// timeout, enable-drop and reset sequences. One line per valid result.
module tb_pwm_capture;

    localparam int CNT_W   = 12;
    localparam int TIMEOUT = 100;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             pwm;
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             timeout;
    logic             level;

    pwm_capture #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .enable_i  (enable),
        .pwm_i     (pwm),
        .duty_o    (duty),
        .period_o  (period),
        .valid_o   (valid),
        .timeout_o (timeout),
        .level_o   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_valids;
        int exp_duty;
        int exp_period;
        int exp_timeout;
    } row_t;

    typedef struct {
        int cyc;
        int duty;
        int period;
    } vrec_t;

    int    cyc_cnt = 0;
    int    total   = 0;
    int    bad     = 0;
    int    chg_err = 0;
    vrec_t vq[$];
    int    rise_q[$];
    int    exp_d;
    int    exp_p;
    bit    gap_chk;
    int    prev_cyc;
    row_t  rows[6];

    logic [CNT_W-1:0] duty_prev   = '0;
    logic [CNT_W-1:0] period_prev = '0;
    logic             rst_prev    = 1'b1;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Records every valid pulse and flags result changes outside valid (reset excepted).
    always @(negedge clk) begin
        if (valid) begin
            vq.push_back('{cyc_cnt, int'(duty), int'(period)});
        end else if (!rst_prev && (duty != duty_prev || period != period_prev)) begin
            chg_err <= chg_err + 1;
        end
        duty_prev   <= duty;
        period_prev <= period;
        rst_prev    <= reset;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic disarm();
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(1);
    endtask

    task automatic drain(input int exp_n, input string tag);
        int    n;
        vrec_t v;
        int    r;
        n = 0;
        while (vq.size() > 0) begin
            v = vq.pop_front();
            n++;
            $display("valid %s: cyc=%0d duty=%0d period=%0d", tag, v.cyc, v.duty, v.period);
            check({tag, "_duty"}, v.duty, exp_d);
            check({tag, "_period"}, v.period, exp_p);
            if (rise_q.size() > 0) begin
                r = rise_q.pop_front();
                check({tag, "_latency"}, v.cyc - r, 4);
            end
            if (gap_chk && prev_cyc >= 0) check({tag, "_gap"}, v.cyc - prev_cyc, exp_p);
            prev_cyc = v.cyc;
        end
        check({tag, "_count"}, n, exp_n);
        rise_q.delete();
    endtask

    initial begin
        rows[0] = '{10, 30, 3, 3, 10,  40, 0};
        rows[1] = '{ 1,  1, 5, 5,  1,   2, 0};
        rows[2] = '{10, 90, 2, 2, 10, 100, 0};
        rows[3] = '{10, 91, 2, 0, 10, 100, 1};
        rows[4] = '{ 3,  5, 3, 3,  3,   8, 0};
        rows[5] = '{ 7,  2, 2, 2,  7,   9, 0};

        reset  = 1'b1;
        enable = 1'b0;
        pwm    = 1'b0;
        tick(3);
        reset  = 1'b0;
        tick(1);
        check("reset_duty", int'(duty), 0);
        check("reset_period", int'(period), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_timeout", int'(timeout), 0);
        check("reset_level", int'(level), 0);

        for (int r = 0; r < 6; r++) begin
            exp_d    = rows[r].exp_duty;
            exp_p    = rows[r].exp_period;
            gap_chk  = 1'b1;
            prev_cyc = -1;
            $display("row %0d: hi=%0d lo=%0d reps=%0d", r, rows[r].hi, rows[r].lo, rows[r].reps);
            disarm();
            for (int i = 0; i <= rows[r].reps; i++) begin
                pwm = 1'b1;
                if (i > 0 && rows[r].exp_valids > 0) rise_q.push_back(cyc_cnt);
                tick(rows[r].hi);
                pwm = 1'b0;
                tick(i < rows[r].reps ? rows[r].lo : 6);
            end
            drain(rows[r].exp_valids, $sformatf("row%0d", r));
            check($sformatf("row%0d_timeout", r), int'(timeout), rows[r].exp_timeout);
            check($sformatf("row%0d_duty_hold", r), int'(duty), rows[r].exp_duty);
            check($sformatf("row%0d_period_hold", r), int'(period), rows[r].exp_period);
        end

        // Input stuck high: timeout exactly TIMEOUT cycles after the FSM armed.
        gap_chk = 1'b0;
        disarm();
        pwm = 1'b1;
        tick(103);
        check("stuck_timeout_early", int'(timeout), 0);
        tick(1);
        check("stuck_timeout", int'(timeout), 1);
        check("stuck_level", int'(level), 1);
        check("stuck_duty_hold", int'(duty), 7);
        check("stuck_period_hold", int'(period), 9);
        tick(20);
        drain(0, "stuck");
        pwm = 1'b0;
        tick(30);
        exp_d = 10;
        exp_p = 40;
        pwm = 1'b1;
        tick(10);
        pwm = 1'b0;
        tick(30);
        check("rearm_timeout_held", int'(timeout), 1);
        pwm = 1'b1;
        rise_q.push_back(cyc_cnt);
        tick(10);
        pwm = 1'b0;
        tick(6);
        drain(1, "resume");
        check("resume_timeout_clear", int'(timeout), 0);

        // Enable dropped mid low phase: interrupted period is discarded.
        disarm();
        pwm = 1'b1;
        tick(10);
        pwm = 1'b0;
        tick(30);
        pwm = 1'b1;
        rise_q.push_back(cyc_cnt);
        tick(10);
        pwm = 1'b0;
        tick(15);
        enable = 1'b0;
        tick(5);
        enable = 1'b1;
        check("en_duty_hold", int'(duty), 10);
        check("en_period_hold", int'(period), 40);
        check("en_timeout_hold", int'(timeout), 0);
        tick(15);
        pwm = 1'b1;
        tick(10);
        pwm = 1'b0;
        tick(30);
        pwm = 1'b1;
        rise_q.push_back(cyc_cnt);
        tick(10);
        pwm = 1'b0;
        tick(6);
        drain(2, "enable");

        // Reset pulsed while the FSM is still in its high phase (pin already low).
        disarm();
        pwm = 1'b1;
        tick(10);
        pwm = 1'b0;
        tick(30);
        pwm = 1'b1;
        rise_q.push_back(cyc_cnt);
        tick(10);
        pwm = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rst_duty", int'(duty), 0);
        check("rst_period", int'(period), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_level", int'(level), 0);
        drain(1, "pre_reset");
        tick(28);
        pwm = 1'b1;
        tick(10);
        pwm = 1'b0;
        tick(30);
        drain(0, "post_reset_arm");
        pwm = 1'b1;
        rise_q.push_back(cyc_cnt);
        tick(10);
        pwm = 1'b0;
        tick(6);
        drain(1, "post_reset");

        check("results_change_only_on_valid", chg_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
